// File: rtl/a2d_pkg.sv
// Shared constants, FSM state type and conversion-channel mux for the A2D SPI serf.
package a2d_pkg;

  localparam int FRAME_LEN = 16;

  localparam logic [2:0] CH_LFT   = 3'b000;
  localparam logic [2:0] CH_RGHT  = 3'b100;
  localparam logic [2:0] CH_STEER = 3'b101;
  localparam logic [2:0] CH_BATT  = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESYNC
  } serf_state_t;

  function automatic logic [11:0] conv_sel(
    input logic [2:0]  ch,
    input logic [11:0] lft,
    input logic [11:0] rght,
    input logic [11:0] steer,
    input logic [11:0] batt
  );
    logic [11:0] val;
    val = 12'h000;
    case (ch)
      CH_LFT:   val = lft;
      CH_RGHT:  val = rght;
      CH_STEER: val = steer;
      CH_BATT:  val = batt;
      default:  val = 12'h000;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/spi_serf_sync.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall detect
// taken from the last two synchronized samples.
module spi_serf_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] ff_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_q   <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      ff_q   <= (ff_q << 1) | STAGES'(async_i);
      prev_q <= ff_q[STAGES-1];
    end
  end

  assign sync_o = ff_q[STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/a2d_spi_serf.sv
// SPI serf returning A2D conversions: each frame's command selects the channel
// whose conversion is shifted out during the following frame.
module a2d_spi_serf #(
  parameter int FRAME_LEN   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] ana_lft,
  input  logic [11:0] ana_rght,
  input  logic [11:0] ana_steer,
  input  logic [11:0] ana_batt,
  output logic        cmd_vld,
  output logic [2:0]  chnnl,
  output logic        frm_err
);
  import a2d_pkg::*;

  // RESYNC must outlast the preset synchronizer contents, otherwise a low SS_n
  // held through reset would look like a fresh fall once the presets drain.
  localparam int             FLUSH   = SYNC_STAGES + 1;
  localparam int             FW      = $clog2(FLUSH + 1);
  localparam logic [FW-1:0]  FLUSH_C = FW'(FLUSH);
  localparam logic [4:0]     LEN_C   = 5'(FRAME_LEN);

  logic ss_sync, ss_rise, ss_fall;
  logic unused_sclk_lvl, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi_sync;

  spi_serf_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(SS_n),
    .sync_o (ss_sync),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_serf_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(SCLK),
    .sync_o (unused_sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_q <= '0;
    else     mosi_q <= (mosi_q << 1) | SYNC_STAGES'(MOSI);
  end
  assign mosi_sync = mosi_q[SYNC_STAGES-1];

  serf_state_t   state_q;
  logic [FW-1:0] flush_q;
  logic [15:0]   tx_q, rx_q;
  logic [4:0]    rise_cnt_q;
  logic [11:0]   conv_q;
  logic [2:0]    chnnl_q;
  logic          cmd_vld_q, frm_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RESYNC;
      flush_q    <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rise_cnt_q <= '0;
      conv_q     <= '0;
      chnnl_q    <= '0;
      cmd_vld_q  <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      cmd_vld_q <= 1'b0;
      frm_err_q <= 1'b0;
      // chnnl_q already holds the new channel in the cycle cmd_vld is high.
      if (cmd_vld_q)
        conv_q <= conv_sel(chnnl_q, ana_lft, ana_rght, ana_steer, ana_batt);
      case (state_q)
        RESYNC: begin
          if (flush_q != FLUSH_C) flush_q <= flush_q + FW'(1);
          else if (ss_sync)       state_q <= IDLE;
        end
        IDLE: begin
          if (ss_fall) begin
            state_q    <= SHIFT;
            tx_q       <= {4'h0, conv_q};
            rise_cnt_q <= '0;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state_q <= IDLE;
            if (rise_cnt_q == LEN_C) begin
              cmd_vld_q <= 1'b1;
              chnnl_q   <= rx_q[13:11];
            end else begin
              frm_err_q <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              rx_q <= {rx_q[14:0], mosi_sync};
              if (rise_cnt_q != 5'd31) rise_cnt_q <= rise_cnt_q + 5'd1;
            end
            if (sclk_fall && rise_cnt_q != 5'd0) tx_q <= {tx_q[14:0], 1'b0};
          end
        end
        default: state_q <= RESYNC;
      endcase
    end
  end

  assign MISO    = ~ss_sync & tx_q[15];
  assign cmd_vld = cmd_vld_q;
  assign frm_err = frm_err_q;
  assign chnnl   = chnnl_q;

endmodule

// File: tb/tb_a2d_spi_serf.sv
// Directed bench for a2d_spi_serf: drives SPI frames as a monarch would and
// checks returned words, pulses and decoded channel against hand-computed values.
module tb_a2d_spi_serf;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst, SS_n, SCLK, MOSI, MISO;
  logic [11:0] ana_lft, ana_rght, ana_steer, ana_batt;
  logic        cmd_vld, frm_err;
  logic [2:0]  chnnl;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cmd   = 0;
  int n_err   = 0;

  always #5 clk = ~clk;

  a2d_spi_serf #(.FRAME_LEN(16), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .ana_lft  (ana_lft),
    .ana_rght (ana_rght),
    .ana_steer(ana_steer),
    .ana_batt (ana_batt),
    .cmd_vld  (cmd_vld),
    .chnnl    (chnnl),
    .frm_err  (frm_err)
  );

  always @(negedge clk) begin
    if (cmd_vld) n_cmd++;
    if (frm_err) n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %h", tag, got);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    @(negedge clk);
    SCLK = 1'b0;
    MOSI = b;
    wait_clk(HALF);
    m = MISO;
    SCLK = 1'b1;
    wait_clk(HALF);
  endtask

  // tog >= 0 changes ana_batt just before that bit, to disturb a frame in flight.
  task automatic xfer(input logic [15:0] cmd, input int nrise, input int tog,
                      output logic [15:0] resp);
    logic m;
    resp = 16'h0000;
    @(negedge clk);
    SS_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nrise; i++) begin
      if (i == tog) ana_batt = 12'hBBB;
      spi_bit(cmd[15-i], m);
      resp = {resp[14:0], m};
    end
    @(negedge clk);
    SS_n = 1'b1;
    MOSI = 1'b0;
    wait_clk(2 * HALF);
    $display("[TB] frame cmd=%h rises=%0d resp=%h chnnl=%b", cmd, nrise, resp, chnnl);
  endtask

  logic [15:0] resp;
  int          c0, e0;
  logic [15:0] rr_cmd [4] = '{16'h0000, 16'h2000, 16'h2800, 16'h3000};
  logic [15:0] rr_exp [4] = '{16'h0111, 16'h0222, 16'h0333, 16'h0444};

  initial begin
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    ana_lft = 12'h111; ana_rght = 12'hA5C; ana_steer = 12'h333; ana_batt = 12'h444;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(10);

    // Reset state
    chk("rst_miso", 32'(MISO), 32'h0);
    chk("rst_chnnl", 32'(chnnl), 32'h0);
    chk("rst_cmd_cnt", n_cmd, 0);
    chk("rst_err_cnt", n_err, 0);
    xfer(16'h0000, 16, -1, resp);
    chk("first_resp", 32'(resp), 32'h0000);
    chk("first_cmd_cnt", n_cmd, 1);

    // Two 0x2000 commands: second returns ana_rght
    xfer(16'h2000, 16, -1, resp);
    chk("rght_1st_resp", 32'(resp), 32'h0111);
    xfer(16'h2000, 16, -1, resp);
    chk("rght_2nd_resp", 32'(resp), 32'h0A5C);
    chk("rght_cmd_cnt", n_cmd, 3);
    chk("rght_chnnl", 32'(chnnl), 32'h4);

    // Round-robin command pairs
    ana_rght = 12'h222;
    for (int k = 0; k < 4; k++) begin
      xfer(rr_cmd[k], 16, -1, resp);
      xfer(rr_cmd[k], 16, -1, resp);
      chk($sformatf("rr_resp_%0d", k), 32'(resp), 32'(rr_exp[k]));
    end
    chk("rr_chnnl", 32'(chnnl), 32'h6);

    // Short frame: 9 rises
    c0 = n_cmd; e0 = n_err;
    xfer(16'h2000, 9, -1, resp);
    chk("short_err", n_err - e0, 1);
    chk("short_no_cmd", n_cmd - c0, 0);
    chk("short_chnnl", 32'(chnnl), 32'h6);
    xfer(16'h0000, 16, -1, resp);
    chk("after_short_resp", 32'(resp), 32'h0444);
    chk("after_short_cmd", n_cmd - c0, 1);
    chk("after_short_chnnl", 32'(chnnl), 32'h0);

    // Reset mid-frame, released with SS_n still low
    c0 = n_cmd; e0 = n_err;
    @(negedge clk);
    SS_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 5; i++) begin
      logic m;
      spi_bit(1'(16'h3000 >> (15 - i)), m);
    end
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);
    chk("midrst_miso", 32'(MISO), 32'h0);
    chk("midrst_chnnl", 32'(chnnl), 32'h0);
    for (int i = 5; i < 16; i++) begin
      logic m;
      spi_bit(1'(16'h3000 >> (15 - i)), m);
    end
    @(negedge clk);
    SS_n = 1'b1;
    wait_clk(2 * HALF);
    chk("midrst_no_cmd", n_cmd - c0, 0);
    chk("midrst_no_err", n_err - e0, 0);
    xfer(16'h2800, 16, -1, resp);
    chk("midrst_next_resp", 32'(resp), 32'h0000);
    chk("midrst_next_cmd", n_cmd - c0, 1);
    chk("midrst_next_chnnl", 32'(chnnl), 32'h5);

    // Unmapped channel 111, then mid-frame ana_batt change
    xfer(16'h3800, 16, -1, resp);
    chk("ch7_prev_resp", 32'(resp), 32'h0333);
    chk("ch7_chnnl", 32'(chnnl), 32'h7);
    xfer(16'h3000, 16, -1, resp);
    chk("ch7_resp", 32'(resp), 32'h0000);
    xfer(16'h0000, 16, 8, resp);
    chk("batt_midframe_resp", 32'(resp), 32'h0444);
    ana_batt = 12'h444;
    chk("final_err_cnt", n_err, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
